// File: rtl/incrementer_pkg.sv
// Shared helpers for the incrementer block (optional INCREMENTER_WRAP_COUNT_EN counter).
package incrementer_pkg;

    localparam int WRAP_CNT_W = 16;

    typedef logic [WRAP_CNT_W-1:0] wrap_cnt_t;

    function automatic wrap_cnt_t sat_inc(input wrap_cnt_t v);
        return (v == '1) ? v : v + wrap_cnt_t'(1);
    endfunction

endpackage

// File: rtl/incrementer_comb.sv
// Modular add of INCREMENT over the range 0..MAX_VALUE, with wrap and range flags.
module incrementer_comb #(
    parameter logic [31:0] MAX_VALUE = 255,
    parameter logic [31:0] INCREMENT = 1,
    localparam int W = $clog2({1'b0, MAX_VALUE} + 33'd1)
) (
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         wrap,
    output logic         range_err
);

    localparam logic [W:0] MAXV = (W+1)'(MAX_VALUE);
    localparam logic [W:0] STEP = (W+1)'(INCREMENT);
    localparam logic [W:0] MODV = MAXV + (W+1)'(1);

    // One extra bit so the compare sees the untruncated sum.
    logic [W:0] sum;

    assign sum = {1'b0, data_in} + STEP;

    always_comb begin
        data_out  = '0;
        wrap      = 1'b0;
        range_err = ({1'b0, data_in} > MAXV);
        if (!range_err) begin
            if (sum > MAXV) begin
                wrap     = 1'b1;
                data_out = W'(sum - MODV);
            end else begin
                data_out = W'(sum);
            end
        end
    end

endmodule

// File: rtl/incrementer.sv
// Incrementer with a one-cycle registered result stage.
// Optional saturating wrap counter enabled by INCREMENTER_WRAP_COUNT_EN.
module incrementer
    import incrementer_pkg::*;
#(
    parameter logic [31:0] MAX_VALUE = 255,
    parameter logic [31:0] INCREMENT = 1,
    localparam int W = $clog2({1'b0, MAX_VALUE} + 33'd1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out,
    output logic         wrap,
    output logic         range_err,
    input  logic         in_valid,
    output logic [W-1:0] q,
    output logic         q_valid,
    output logic         q_wrap
`ifdef INCREMENTER_WRAP_COUNT_EN
    ,
    output wrap_cnt_t    wrap_count
`endif
);

    if (INCREMENT > MAX_VALUE || MAX_VALUE == 0) begin : g_bad_cfg
        $fatal(1, "incrementer: need 0 < MAX_VALUE and INCREMENT <= MAX_VALUE");
    end

    incrementer_comb #(
        .MAX_VALUE (MAX_VALUE),
        .INCREMENT (INCREMENT)
    ) u_comb (
        .data_in   (data_in),
        .data_out  (data_out),
        .wrap      (wrap),
        .range_err (range_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            q_valid <= 1'b0;
            q_wrap  <= 1'b0;
        end else begin
            q_valid <= in_valid;
            if (in_valid) begin
                q      <= data_out;
                q_wrap <= wrap;
            end
        end
    end

`ifdef INCREMENTER_WRAP_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_count <= '0;
        end else if (in_valid && wrap) begin
            wrap_count <= sat_inc(wrap_count);
        end
    end
`endif

endmodule

// File: tb/tb_incrementer.sv
// Randomised bench for incrementer: two instances (255/1 and 9/3) against
// a modulo-arithmetic reference model, plus directed literal checks.
module tb_incrementer;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [7:0] da, oa, qa;
    logic       wa, ea, va, qva, qwa;
    logic [3:0] db, ob, qb;
    logic       wb, eb, vb, qvb, qwb;
`ifdef INCREMENTER_WRAP_COUNT_EN
    logic [15:0] wca, wcb;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    incrementer #(.MAX_VALUE(255), .INCREMENT(1)) u_a (
        .clk(clk), .reset(reset), .data_in(da), .data_out(oa),
        .wrap(wa), .range_err(ea), .in_valid(va), .q(qa),
        .q_valid(qva), .q_wrap(qwa)
`ifdef INCREMENTER_WRAP_COUNT_EN
        , .wrap_count(wca)
`endif
    );

    incrementer #(.MAX_VALUE(9), .INCREMENT(3)) u_b (
        .clk(clk), .reset(reset), .data_in(db), .data_out(ob),
        .wrap(wb), .range_err(eb), .in_valid(vb), .q(qb),
        .q_valid(qvb), .q_wrap(qwb)
`ifdef INCREMENTER_WRAP_COUNT_EN
        , .wrap_count(wcb)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Reference: result is (x+inc) mod (max+1); out-of-range inputs give 0.
    function automatic void ref_f(input int unsigned mx, input int unsigned inc,
                                  input int unsigned din, output int unsigned o,
                                  output bit w, output bit e);
        int unsigned s;
        s = din + inc;
        if (din > mx) begin
            o = 0; w = 0; e = 1;
        end else begin
            o = s % (mx + 1); w = (s > mx); e = 0;
        end
    endfunction

    int unsigned mq_a, mq_b, mc_a, mc_b;
    bit mv_a, mw_a, mv_b, mw_b;

    always @(posedge clk or negedge reset) begin
        int unsigned o;
        bit w, e;
        if (!reset) begin
            mq_a = 0; mv_a = 0; mw_a = 0; mc_a = 0;
            mq_b = 0; mv_b = 0; mw_b = 0; mc_b = 0;
        end else begin
            ref_f(255, 1, da, o, w, e);
            mv_a = va;
            if (va) begin
                mq_a = o; mw_a = w;
                if (w && mc_a < 65535) mc_a++;
            end
            ref_f(9, 3, db, o, w, e);
            mv_b = vb;
            if (vb) begin
                mq_b = o; mw_b = w;
                if (w && mc_b < 65535) mc_b++;
            end
        end
    end

    always @(negedge clk) begin
        int unsigned o;
        bit w, e;
        ref_f(255, 1, da, o, w, e);
        chk("a_data_out", oa, o);
        chk("a_wrap", wa, w);
        chk("a_range_err", ea, e);
        chk("a_q", qa, mq_a);
        chk("a_q_valid", qva, mv_a);
        chk("a_q_wrap", qwa, mw_a);
        ref_f(9, 3, db, o, w, e);
        chk("b_data_out", ob, o);
        chk("b_wrap", wb, w);
        chk("b_range_err", eb, e);
        chk("b_q", qb, mq_b);
        chk("b_q_valid", qvb, mv_b);
        chk("b_q_wrap", qwb, mw_b);
`ifdef INCREMENTER_WRAP_COUNT_EN
        chk("a_wrap_count", wca, mc_a);
        chk("b_wrap_count", wcb, mc_b);
`endif
    end

    initial begin
        da = 0; db = 0; va = 0; vb = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", qa, 0);
        chk("reset_q_valid", qva, 0);
        chk("reset_q_wrap", qwa, 0);
        #1 reset = 1'b1;

        // Combinational literals
        @(posedge clk); #2;
        da = 8'd254; #1;
        chk("lit_254_out", oa, 255);
        chk("lit_254_wrap", wa, 0);
        da = 8'd255; #1;
        chk("lit_255_out", oa, 0);
        chk("lit_255_wrap", wa, 1);
        db = 4'd6; #1;
        chk("lit_b6_out", ob, 9);
        chk("lit_b6_wrap", wb, 0);
        db = 4'd8; #1;
        chk("lit_b8_out", ob, 1);
        chk("lit_b8_wrap", wb, 1);
        db = 4'd12; #1;
        chk("lit_b12_out", ob, 0);
        chk("lit_b12_err", eb, 1);
        chk("lit_b12_wrap", wb, 0);

        // Registered stage, then async reset mid-cycle
        @(posedge clk); #2;
        da = 8'd5; va = 1'b1;
        @(posedge clk); #1;
        chk("reg_q_load", qa, 6);
        chk("reg_q_valid1", qva, 1);
        va = 1'b0;
        @(posedge clk); #1;
        chk("reg_q_hold", qa, 6);
        chk("reg_q_valid0", qva, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_q", qa, 0);
        chk("async_q_valid", qva, 0);
        @(posedge clk); #1;
        chk("held_q", qa, 0);
        #1 reset = 1'b1;

`ifdef INCREMENTER_WRAP_COUNT_EN
        @(posedge clk); #2;
        da = 8'd255; va = 1'b1;
        repeat (3) @(posedge clk);
        #2 va = 1'b0;
        #1 chk("wrap_count_3", wca, 3);
`endif

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            da = 8'($urandom_range(0, 255));
            db = 4'($urandom_range(0, 15));
            va = 1'($urandom);
            vb = 1'($urandom);
            if (i == 200) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

`ifdef INCREMENTER_WRAP_COUNT_EN
        @(posedge clk); #2;
        da = 8'd255; va = 1'b1;
        repeat (65540) @(posedge clk);
        #2 va = 1'b0;
        #1 chk("wrap_count_sat", wca, 16'hFFFF);
`endif

        @(posedge clk); #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
